fc_update_gen: RTL
==================

# fc_update_gen

Receiver-side flow-control credit return for VC0. Tracks CREDITS_ALLOCATED for the six credit types (PH, PD, NPH, NPD, CplH, CplD) as the receive buffers free entries. Schedules UpdateFC DLLPs (P, NP, Cpl) toward the transmit path on a valid/ready interface, using round-robin arbitration plus a periodic refresh timer. It sits between the RX credit buffers and the DLLP transmit mux; its DLLPs become the far-end transmitter's credit limits.

## Interface
- VC_ID, 0 — virtual channel, placed in DLLP type byte bits [2:0]
- HDR_W, 8 — header credit counter width
- DATA_W, 12 — data credit counter width
- REL_W, 3 — data release count width (legal 0..4)
- P_HDR_INIT / P_DATA_INIT, 8'h20 / 12'h100 — posted InitFC
- NP_HDR_INIT / NP_DATA_INIT, 8'h20 / 12'h010 — non-posted InitFC
- CPL_HDR_INIT / CPL_DATA_INIT, 0 / 0 — completion InitFC; 0 means infinite
- UPDATE_PERIOD, 1024 — refresh interval in cycles, ≥ 4
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- p_hdr_rel, np_hdr_rel, cpl_hdr_rel  in  1 each  one header credit freed
- p_data_rel, np_data_rel, cpl_data_rel  in  REL_W each  data credits freed this cycle
- dllp_valid  out  1  DLLP available
- dllp_ready  in  1  consumer accepts
- dllp_data  out  32  UpdateFC body
- fc_pending  out  3  pending flags {Cpl, NP, P}

## Operation
- Reset values:
  - Counters = their INIT values.
  - fc_pending = 0, timer = 0, RR pointer = P.
  - dllp_valid = 0, dllp_data = 0.
- Release handling:
  - hdr_rel adds 1 to the header counter; data_rel adds its count to the data counter.
  - Arithmetic is modulo 2^HDR_W / 2^DATA_W; wrap is silent.
  - Any nonzero release sets that class's pending flag.
  - Data counts > 4 are illegal; the bench asserts on them. RTL adds them unchanged.
- Infinite field (INIT = 0): counter is held at 0 and releases to it are ignored. Releases still set pending.
- DLLP format:
  - [31:24] type: P = 8'h80|VC_ID, NP = 8'h90|VC_ID, Cpl = 8'hA0|VC_ID.
  - [23:22] = 0 (HdrScale).
  - [21:14] = HdrFC.
  - [13:12] = 0 (DataScale).
  - [11:0] = DataFC.
- Output register is free when dllp_valid = 0 or (dllp_valid & dllp_ready).
- Load rule: when the output register is free and any flag is pending:
  - Select round-robin from the pointer, order P→NP→Cpl.
  - Snapshot the registered (pre-increment) counters of that class into dllp_data.
  - Set dllp_valid and clear the class's pending flag.
  - Move the pointer to the class after the winner.
- Hold rule: while dllp_valid & !dllp_ready, dllp_data and dllp_valid are stable. Counters and pending flags keep updating.
- Timer:
  - Counts 0..UPDATE_PERIOD-1.
  - On the terminal count it sets all three pending flags and wraps to 0.
  - Runs continuously, independent of handshake.
- Set wins over clear: a release or timer expiry in the same cycle as a load of that class leaves the flag set. The later DLLP carries the new value.
- No DLLP is issued unless a flag is pending.

## Timing
- Release sampled in cycle t → counter and pending updated in t+1 → dllp_valid high in t+2 (output free, class wins), carrying the updated value.
- Throughput: one DLLP per cycle. A new DLLP loads in the same edge that completes the handshake.
- Reset mid-transfer:
  - dllp_valid drops the following cycle; the held DLLP is discarded.
  - Counters return to INIT.
- First timer-driven DLLPs appear UPDATE_PERIOD+1 cycles after reset release, as P, NP, Cpl on consecutive cycles with ready held high.

## Structure
- Package fc_pkg:
  - DLLP type constants (UPDATEFC_P/NP/CPL).
  - Class enum {FC_P, FC_NP, FC_CPL}.
  - HDR_W/DATA_W defaults.
  - Field bit positions.
- Sub-module fc_alloc_counter, instanced once per class:
  - Header counter, data counter, infinite-credit handling and pending flag.
  - Inputs: set, clear and release.
- Top level holds the timer, RR arbiter and output register.

## Test plan
- Reset: after rst deasserts → dllp_valid = 0 and fc_pending = 0 for UPDATE_PERIOD cycles.
- Single release: one p_hdr_rel pulse, ready = 1 → dllp_data = 32'h80084100 (HdrFC 8'h21, DataFC 12'h100) two cycles later, valid for one cycle.
- Backpressure: ready = 0 for 10 cycles with 3 extra p_hdr_rel → dllp_data stable. After accept, the next DLLP carries HdrFC 8'h24 one cycle later.
- Arbitration: p/np/cpl releases in the same cycle, ready = 1 → P, NP, Cpl on three consecutive cycles, then idle.
- Wrap: NP_DATA_INIT = 12'hFFE, np_data_rel = 4 → DataFC 12'h002. Infinite: cpl_hdr_rel ×5 → Cpl HdrFC stays 0, DLLP still emitted.
- Timer plus collision: UPDATE_PERIOD = 16, no releases → P/NP/Cpl burst every 16 cycles. A release on the load cycle of its class produces a second DLLP with the incremented value.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for VC0 UpdateFC credit return: DLLP type codes,
// credit class encoding and UpdateFC field layout.
package fc_pkg;

  localparam logic [7:0] UPDATEFC_P   = 8'h80;
  localparam logic [7:0] UPDATEFC_NP  = 8'h90;
  localparam logic [7:0] UPDATEFC_CPL = 8'hA0;

  localparam int HDR_W_DEF  = 8;
  localparam int DATA_W_DEF = 12;

  localparam int TYPE_LSB      = 24;
  localparam int HDRSCALE_LSB  = 22;
  localparam int HDRFC_LSB     = 14;
  localparam int DATASCALE_LSB = 12;
  localparam int DATAFC_LSB    = 0;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_class_e;

  function automatic logic [31:0] pack_updatefc(input logic [7:0]  typ,
                                                input logic [7:0]  hdr_fc,
                                                input logic [11:0] data_fc);
    logic [31:0] d;
    d = '0;
    d[TYPE_LSB +: 8]       = typ;
    d[HDRSCALE_LSB +: 2]   = 2'b00;
    d[HDRFC_LSB +: 8]      = hdr_fc;
    d[DATASCALE_LSB +: 2]  = 2'b00;
    d[DATAFC_LSB +: 12]    = data_fc;
    return d;
  endfunction

  // Round-robin successor, P -> NP -> Cpl -> P.
  function automatic fc_class_e next_class(input fc_class_e c);
    fc_class_e n;
    case (c)
      FC_P:    n = FC_NP;
      FC_NP:   n = FC_CPL;
      default: n = FC_P;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fc_update_gen_counter.sv
// Per-class CREDITS_ALLOCATED tracker: header/data counters plus the
// "UpdateFC owed" pending flag. An INIT of zero marks that field infinite.
module fc_alloc_counter
  import fc_pkg::*;
#(
  parameter int                HDR_W     = HDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                REL_W     = 3,
  parameter logic [HDR_W-1:0]  HDR_INIT  = '0,
  parameter logic [DATA_W-1:0] DATA_INIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_set,
  input  logic              i_clr,
  input  logic              i_hdr_rel,
  input  logic [REL_W-1:0]  i_data_rel,
  output logic [HDR_W-1:0]  o_hdr,
  output logic [DATA_W-1:0] o_data,
  output logic              o_pend
);

  localparam bit HDR_INF  = (HDR_INIT == '0);
  localparam bit DATA_INF = (DATA_INIT == '0);

  logic [HDR_W-1:0]  r_hdr;
  logic [DATA_W-1:0] r_data;
  logic              r_pend;
  logic              w_rel_any;

  assign w_rel_any = i_hdr_rel | (|i_data_rel);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdr  <= HDR_INIT;
      r_data <= DATA_INIT;
      r_pend <= 1'b0;
    end else begin
      if (!HDR_INF && i_hdr_rel)
        r_hdr <= r_hdr + HDR_W'(1);
      if (!DATA_INF)
        r_data <= r_data + DATA_W'(i_data_rel);
      // A new release or refresh in the load cycle must survive the clear.
      if (i_set || w_rel_any)
        r_pend <= 1'b1;
      else if (i_clr)
        r_pend <= 1'b0;
    end
  end

  assign o_hdr  = r_hdr;
  assign o_data = r_data;
  assign o_pend = r_pend;

endmodule

// File: rtl/fc_update_gen.sv
// VC0 receiver credit return: refresh timer, round-robin pick among pending
// classes and a valid/ready UpdateFC DLLP output register.
module fc_update_gen
  import fc_pkg::*;
#(
  parameter logic [2:0]        VC_ID         = 3'd0,
  parameter int                HDR_W         = HDR_W_DEF,
  parameter int                DATA_W        = DATA_W_DEF,
  parameter int                REL_W         = 3,
  parameter logic [HDR_W-1:0]  P_HDR_INIT    = 8'h20,
  parameter logic [DATA_W-1:0] P_DATA_INIT   = 12'h100,
  parameter logic [HDR_W-1:0]  NP_HDR_INIT   = 8'h20,
  parameter logic [DATA_W-1:0] NP_DATA_INIT  = 12'h010,
  parameter logic [HDR_W-1:0]  CPL_HDR_INIT  = '0,
  parameter logic [DATA_W-1:0] CPL_DATA_INIT = '0,
  parameter int                UPDATE_PERIOD = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             p_hdr_rel,
  input  logic             np_hdr_rel,
  input  logic             cpl_hdr_rel,
  input  logic [REL_W-1:0] p_data_rel,
  input  logic [REL_W-1:0] np_data_rel,
  input  logic [REL_W-1:0] cpl_data_rel,
  output logic             dllp_valid,
  input  logic             dllp_ready,
  output logic [31:0]      dllp_data,
  output logic [2:0]       fc_pending
);

  localparam int TMR_W = (UPDATE_PERIOD > 1) ? $clog2(UPDATE_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(UPDATE_PERIOD - 1);

  logic [TMR_W-1:0]  r_timer;
  logic              r_valid;
  logic [31:0]       r_data;
  fc_class_e         r_ptr;

  logic              w_tmr_tc;
  logic              w_free;
  logic              w_any;
  logic              w_load;
  fc_class_e         w_win;
  logic [2:0]        w_pend;
  logic [2:0]        w_clr;
  logic [31:0]       w_next;
  logic [HDR_W-1:0]  w_hdr  [3];
  logic [DATA_W-1:0] w_data [3];

  fc_alloc_counter #(
    .HDR_W(HDR_W), .DATA_W(DATA_W), .REL_W(REL_W),
    .HDR_INIT(P_HDR_INIT), .DATA_INIT(P_DATA_INIT)
  ) u_cnt_p (
    .clk(clk), .rst(rst), .i_set(w_tmr_tc), .i_clr(w_clr[0]),
    .i_hdr_rel(p_hdr_rel), .i_data_rel(p_data_rel),
    .o_hdr(w_hdr[0]), .o_data(w_data[0]), .o_pend(w_pend[0])
  );

  fc_alloc_counter #(
    .HDR_W(HDR_W), .DATA_W(DATA_W), .REL_W(REL_W),
    .HDR_INIT(NP_HDR_INIT), .DATA_INIT(NP_DATA_INIT)
  ) u_cnt_np (
    .clk(clk), .rst(rst), .i_set(w_tmr_tc), .i_clr(w_clr[1]),
    .i_hdr_rel(np_hdr_rel), .i_data_rel(np_data_rel),
    .o_hdr(w_hdr[1]), .o_data(w_data[1]), .o_pend(w_pend[1])
  );

  fc_alloc_counter #(
    .HDR_W(HDR_W), .DATA_W(DATA_W), .REL_W(REL_W),
    .HDR_INIT(CPL_HDR_INIT), .DATA_INIT(CPL_DATA_INIT)
  ) u_cnt_cpl (
    .clk(clk), .rst(rst), .i_set(w_tmr_tc), .i_clr(w_clr[2]),
    .i_hdr_rel(cpl_hdr_rel), .i_data_rel(cpl_data_rel),
    .o_hdr(w_hdr[2]), .o_data(w_data[2]), .o_pend(w_pend[2])
  );

  assign w_tmr_tc = (r_timer == TMR_LAST);
  assign w_free   = !r_valid || dllp_ready;
  assign w_any    = |w_pend;
  assign w_load   = w_free && w_any;

  // First pending class at or after the pointer wins.
  always_comb begin
    w_win = r_ptr;
    case (r_ptr)
      FC_P:    w_win = w_pend[0] ? FC_P   : (w_pend[1] ? FC_NP  : FC_CPL);
      FC_NP:   w_win = w_pend[1] ? FC_NP  : (w_pend[2] ? FC_CPL : FC_P);
      default: w_win = w_pend[2] ? FC_CPL : (w_pend[0] ? FC_P   : FC_NP);
    endcase
  end

  always_comb begin
    w_clr = '0;
    if (w_load)
      w_clr[w_win] = 1'b1;
  end

  always_comb begin
    w_next = '0;
    case (w_win)
      FC_P:    w_next = pack_updatefc(UPDATEFC_P   | {5'b0, VC_ID}, 8'(w_hdr[0]), 12'(w_data[0]));
      FC_NP:   w_next = pack_updatefc(UPDATEFC_NP  | {5'b0, VC_ID}, 8'(w_hdr[1]), 12'(w_data[1]));
      FC_CPL:  w_next = pack_updatefc(UPDATEFC_CPL | {5'b0, VC_ID}, 8'(w_hdr[2]), 12'(w_data[2]));
      default: w_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ptr   <= FC_P;
    end else begin
      r_timer <= w_tmr_tc ? '0 : r_timer + TMR_W'(1);
      if (w_free) begin
        r_valid <= w_any;
        if (w_any) begin
          r_data <= w_next;
          r_ptr  <= next_class(w_win);
        end
      end
    end
  end

  assign dllp_valid = r_valid;
  assign dllp_data  = r_data;
  assign fc_pending = w_pend;

endmodule
